stream_checker: RTL and testbench

Receive-side companion to the counter-paced data generator. Samples an 8-bit `data` stream on each `valid` pulse and checks two things: the pulse spacing equals `PERIOD` cycles, and each captured value equals the previous one plus `PERIOD` modulo 2^`DATA_WIDTH`. It acquires and reports lock, and it flags and counts errors. It sits in the unit-test harness directly on the generator's `data`/`valid` outputs and gives the bench a single pass/fail observation point.

---
 rtl/stream_check_pkg.sv | 28 ++
 rtl/interval_timer.sv | 41 ++++
 rtl/stream_checker.sv | 167 ++++++++++++++++
 tb/tb_stream_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_check_pkg
//  Description : Shared types and default constants for the stream checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_check_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } chk_state_t;

    typedef logic [1:0] err_kind_t;

    localparam err_kind_t ERR_NONE     = 2'b00;
    localparam err_kind_t ERR_DATA     = 2'b01;
    localparam err_kind_t ERR_INTERVAL = 2'b10;
    localparam err_kind_t ERR_TIMEOUT  = 2'b11;

    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_PERIOD     = 4;
    localparam int c_DEF_LOCK_COUNT = 3;
    localparam int c_DEF_ERR_WIDTH  = 16;

endpackage
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
//  Module      : interval_timer
//  Description : Counts cycles since the last valid strobe and flags when the
//                next strobe is due (on_time) or has been missed (late).
//  Revision    : 1.0 - initial release
// ============================================================================
module interval_timer
    import stream_check_pkg::*;
#(
    parameter int PERIOD = c_DEF_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic valid,
    output logic on_time,
    output logic late
);

    localparam int c_CNT_W = $clog2(PERIOD + 2);
    localparam logic [c_CNT_W-1:0] c_PERIOD  = c_CNT_W'(PERIOD);
    localparam logic [c_CNT_W-1:0] c_GAP_MAX = c_CNT_W'(PERIOD + 1);

    logic [c_CNT_W-1:0] r_gap_cnt;

    // Restart at 1 on every strobe, otherwise count up and park one past PERIOD
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gap_cnt <= '0;
        end else if (valid) begin
            r_gap_cnt <= c_CNT_W'(1);
        end else if (r_gap_cnt != c_GAP_MAX) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    assign on_time = (r_gap_cnt == c_PERIOD);
    assign late    = on_time && !valid;

endmodule
`default_nettype wire

// File: rtl/stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : stream_checker
//  Description : Checks a counter-paced data stream for correct strobe spacing
//                and data increment; reports lock, error pulses, error kind
//                and a saturating error count.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_checker
    import stream_check_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int PERIOD     = c_DEF_PERIOD,
    parameter int LOCK_COUNT = c_DEF_LOCK_COUNT,
    parameter int ERR_WIDTH  = c_DEF_ERR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    input  logic                  clear_errors,
    output logic                  locked,
    output logic                  error,
    output logic [1:0]            err_kind,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [DATA_WIDTH-1:0] last_data
);

    localparam int c_GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [c_GOOD_W-1:0]   c_LOCK_TARGET = c_GOOD_W'(LOCK_COUNT);
    localparam logic [DATA_WIDTH-1:0] c_STEP        = DATA_WIDTH'(PERIOD);

    chk_state_t            r_state;
    chk_state_t            w_state_next;
    logic [c_GOOD_W-1:0]   r_good_cnt;
    logic [c_GOOD_W-1:0]   w_good_next;
    logic [c_GOOD_W-1:0]   w_good_inc;
    logic                  r_locked;
    logic                  w_locked_next;
    logic [DATA_WIDTH-1:0] r_last_data;
    logic [DATA_WIDTH-1:0] w_last_next;
    logic [DATA_WIDTH-1:0] w_expected;
    logic                  w_err_hit;
    err_kind_t             w_err_new;
    logic                  w_on_time;
    logic                  w_late;
    logic                  r_error;
    err_kind_t             r_err_kind;
    logic [ERR_WIDTH-1:0]  r_err_count;

    interval_timer #(
        .PERIOD (PERIOD)
    ) u_interval_timer (
        .clock   (clock),
        .reset   (reset),
        .valid   (valid),
        .on_time (w_on_time),
        .late    (w_late)
    );

    // Wrap-around is intentional: the generator counts modulo 2^DATA_WIDTH
    assign w_expected = r_last_data + c_STEP;
    assign w_good_inc = r_good_cnt + 1'b1;

    // Next-state, lock tracking and error classification
    always_comb begin
        w_state_next  = r_state;
        w_good_next   = r_good_cnt;
        w_locked_next = r_locked;
        w_last_next   = r_last_data;
        w_err_hit     = 1'b0;
        w_err_new     = ERR_NONE;

        // Every sample, good or bad, becomes the new data reference
        if (valid) begin
            w_last_next = data;
        end

        case (r_state)
            SEARCH: begin
                if (valid) begin
                    w_good_next  = '0;
                    w_state_next = ACQUIRE;
                end
            end
            ACQUIRE, LOCKED: begin
                if (valid) begin
                    if (!w_on_time) begin
                        w_err_hit = 1'b1;
                        w_err_new = ERR_INTERVAL;
                    end else if (data != w_expected) begin
                        w_err_hit = 1'b1;
                        w_err_new = ERR_DATA;
                    end

                    if (w_err_hit) begin
                        w_state_next  = ACQUIRE;
                        w_good_next   = '0;
                        w_locked_next = 1'b0;
                    end else if (r_state == ACQUIRE) begin
                        w_good_next = w_good_inc;
                        if (w_good_inc == c_LOCK_TARGET) begin
                            w_state_next  = LOCKED;
                            w_locked_next = 1'b1;
                        end
                    end
                end else if (w_late) begin
                    w_err_hit     = 1'b1;
                    w_err_new     = ERR_TIMEOUT;
                    w_state_next  = SEARCH;
                    w_good_next   = '0;
                    w_locked_next = 1'b0;
                end
            end
            default: begin
                w_state_next  = SEARCH;
                w_good_next   = '0;
                w_locked_next = 1'b0;
            end
        endcase
    end

    // State, good-sample counter, lock flag and data reference registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= SEARCH;
            r_good_cnt  <= '0;
            r_locked    <= 1'b0;
            r_last_data <= '0;
        end else begin
            r_state     <= w_state_next;
            r_good_cnt  <= w_good_next;
            r_locked    <= w_locked_next;
            r_last_data <= w_last_next;
        end
    end

    // Error pulse, sticky kind and saturating count; a new error outranks a clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_error     <= 1'b0;
            r_err_kind  <= ERR_NONE;
            r_err_count <= '0;
        end else begin
            r_error <= w_err_hit;
            if (w_err_hit) begin
                r_err_kind <= w_err_new;
                if (clear_errors) begin
                    r_err_count <= ERR_WIDTH'(1);
                end else if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end else if (clear_errors) begin
                r_err_kind  <= ERR_NONE;
                r_err_count <= '0;
            end
        end
    end

    assign locked    = r_locked;
    assign error     = r_error;
    assign err_kind  = r_err_kind;
    assign err_count = r_err_count;
    assign last_data = r_last_data;

endmodule
`default_nettype wire

// File: tb/tb_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_checker
//  Description : Scenario bench for stream_checker: lock, wrap-around, data,
//                interval and timeout errors, clear/saturation, mid-stream reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_checker;
    import stream_check_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        clear_errors = 1'b0;
    logic [7:0]  data = 8'h00;

    logic        locked, error;
    logic [1:0]  err_kind;
    logic [15:0] err_count;
    logic [7:0]  last_data;

    logic        s_locked, s_error;
    logic [1:0]  s_err_kind;
    logic [1:0]  s_err_count;
    logic [7:0]  s_last_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    stream_checker #(
        .DATA_WIDTH (8), .PERIOD (4), .LOCK_COUNT (3), .ERR_WIDTH (16)
    ) dut (
        .clock (clock), .reset (reset), .data (data), .valid (valid),
        .clear_errors (clear_errors), .locked (locked), .error (error),
        .err_kind (err_kind), .err_count (err_count), .last_data (last_data)
    );

    stream_checker #(
        .DATA_WIDTH (8), .PERIOD (4), .LOCK_COUNT (3), .ERR_WIDTH (2)
    ) dut_s (
        .clock (clock), .reset (reset), .data (data), .valid (valid),
        .clear_errors (clear_errors), .locked (s_locked), .error (s_error),
        .err_kind (s_err_kind), .err_count (s_err_count), .last_data (s_last_data)
    );

    typedef struct packed {
        logic        lk;
        logic        er;
        logic [1:0]  kind;
        logic [15:0] cnt;
        logic [7:0]  last;
    } obs_t;

    obs_t sb[$];

    function automatic obs_t mk(input logic lk, input logic er, input logic [1:0] k,
                                input int c, input logic [7:0] l);
        obs_t o;
        o.lk = lk; o.er = er; o.kind = k; o.cnt = 16'(c); o.last = l;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.lk = locked; o.er = error; o.kind = err_kind; o.cnt = err_count; o.last = last_data;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("locked=%0b error=%0b kind=%b cnt=%0d last=%02h",
                         o.lk, o.er, o.kind, o.cnt, o.last);
    endfunction

    // Stimulus only: one-cycle strobe, returns at the negedge after the capturing edge
    task automatic pulse(input logic [7:0] d);
        data  = d;
        valid = 1'b1;
        @(negedge clock);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        obs_t e, g;
        idle(3);
        sb.push_back(mk(0, 0, ERR_NONE, 0, 8'h00));
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL reset: got %s required %s", fmt(g), fmt(e));
        end
        n_checks++;
        if ({s_locked, s_error, s_err_kind, s_err_count, s_last_data} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_sat: got kind=%b cnt=%0d last=%02h required all zero",
                     s_err_kind, s_err_count, s_last_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_lock();
        obs_t e, g;
        logic [7:0] vals [4];
        vals = '{8'h10, 8'h14, 8'h18, 8'h1C};
        idle(2);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(3);
            sb.push_back(mk(i == 3, 0, ERR_NONE, 0, vals[i]));
            pulse(vals[i]);
            e = sb.pop_front(); g = observe(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL clean_lock[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_wraparound();
        obs_t e, g;
        logic [7:0] d;
        d = 8'h1C;
        for (int i = 0; i < 58; i++) begin
            d = d + 8'd4;
            idle(3);
            sb.push_back(mk(1, 0, ERR_NONE, 0, d));
            pulse(d);
            e = sb.pop_front(); g = observe(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
        end
        n_checks++;
        if (last_data !== 8'h04) begin
            n_fail++;
            $display("FAIL wrap_last: got %02h required 04", last_data);
        end
    endtask

    task automatic test_data_error();
        obs_t e, g;
        logic [7:0] vals [3];
        vals = '{8'h29, 8'h2D, 8'h31};
        for (int d = 8; d <= 32; d += 4) begin
            idle(3);
            sb.push_back(mk(1, 0, ERR_NONE, 0, 8'(d)));
            pulse(8'(d));
            e = sb.pop_front(); g = observe(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL pre_err[%02h]: got %s required %s", d, fmt(g), fmt(e));
            end
        end
        idle(3);
        sb.push_back(mk(0, 1, ERR_DATA, 1, 8'h25));
        pulse(8'h25);
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL data_err: got %s required %s", fmt(g), fmt(e));
        end
        sb.push_back(mk(0, 0, ERR_DATA, 1, 8'h25));
        idle(1);
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL data_err_pulse: got %s required %s", fmt(g), fmt(e));
        end
        idle(2);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) idle(3);
            sb.push_back(mk(i == 2, 0, ERR_DATA, 1, vals[i]));
            pulse(vals[i]);
            e = sb.pop_front(); g = observe(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL relock[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_interval_timeout();
        obs_t e, g;
        idle(2);
        sb.push_back(mk(0, 1, ERR_INTERVAL, 2, 8'h35));
        pulse(8'h35);
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL interval: got %s required %s", fmt(g), fmt(e));
        end
        idle(3);
        sb.push_back(mk(0, 0, ERR_INTERVAL, 2, 8'h39));
        pulse(8'h39);
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL post_interval: got %s required %s", fmt(g), fmt(e));
        end
        sb.push_back(mk(0, 1, ERR_TIMEOUT, 3, 8'h39));
        idle(4);
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL timeout: got %s required %s", fmt(g), fmt(e));
        end
        sb.push_back(mk(0, 0, ERR_TIMEOUT, 3, 8'h39));
        idle(6);
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL search_quiet: got %s required %s", fmt(g), fmt(e));
        end
        sb.push_back(mk(0, 0, ERR_TIMEOUT, 3, 8'h77));
        pulse(8'h77);
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL reacquire: got %s required %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_clear_saturation();
        obs_t e, g;
        logic [1:0] s_exp;
        n_checks++;
        if (s_err_count !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_pre: got %0d required 3", s_err_count);
        end
        clear_errors = 1'b1;
        sb.push_back(mk(0, 0, ERR_NONE, 0, 8'h77));
        idle(1);
        clear_errors = 1'b0;
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL clear_alone: got %s required %s", fmt(g), fmt(e));
        end
        n_checks++;
        if ({s_err_kind, s_err_count} !== 4'b0000) begin
            n_fail++;
            $display("FAIL clear_alone_sat: got kind=%b cnt=%0d required kind=00 cnt=0",
                     s_err_kind, s_err_count);
        end
        // Back-to-back strobes: every one violates spacing
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(0, 1, ERR_INTERVAL, i + 1, 8'(i)));
            s_exp = (i >= 2) ? 2'd3 : 2'(i + 1);
            pulse(8'(i));
            e = sb.pop_front(); g = observe(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
            n_checks++;
            if (s_err_count !== s_exp || s_error !== 1'b1) begin
                n_fail++;
                $display("FAIL sat[%0d]: got cnt=%0d error=%b required cnt=%0d error=1",
                         i, s_err_count, s_error, s_exp);
            end
        end
        clear_errors = 1'b1;
        sb.push_back(mk(0, 1, ERR_INTERVAL, 1, 8'h04));
        pulse(8'h04);
        clear_errors = 1'b0;
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL clear_with_err: got %s required %s", fmt(g), fmt(e));
        end
        n_checks++;
        if (s_err_count !== 2'd1 || s_err_kind !== ERR_INTERVAL) begin
            n_fail++;
            $display("FAIL clear_with_err_sat: got cnt=%0d kind=%b required cnt=1 kind=10",
                     s_err_count, s_err_kind);
        end
    endtask

    task automatic test_reset_midop();
        obs_t e, g;
        logic [7:0] pre [3];
        logic [7:0] post [4];
        pre  = '{8'h08, 8'h0C, 8'h10};
        post = '{8'h40, 8'h44, 8'h48, 8'h4C};
        for (int i = 0; i < 3; i++) begin
            idle(3);
            sb.push_back(mk(i == 2, 0, ERR_INTERVAL, 1, pre[i]));
            pulse(pre[i]);
            e = sb.pop_front(); g = observe(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL prelock[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
        end
        idle(1);
        reset = 1'b1;
        sb.push_back(mk(0, 0, ERR_NONE, 0, 8'h00));
        idle(1);
        reset = 1'b0;
        e = sb.pop_front(); g = observe(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL midreset: got %s required %s", fmt(g), fmt(e));
        end
        n_checks++;
        if ({s_locked, s_error, s_err_kind, s_err_count, s_last_data} !== 14'd0) begin
            n_fail++;
            $display("FAIL midreset_sat: got locked=%b cnt=%0d last=%02h required all zero",
                     s_locked, s_err_count, s_last_data);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle(3);
            sb.push_back(mk(i == 3, 0, ERR_NONE, 0, post[i]));
            pulse(post[i]);
            e = sb.pop_front(); g = observe(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL postreset[%0d]: got %s required %s", i, fmt(g), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_wraparound();
        test_data_error();
        test_interval_timeout();
        test_clear_saturation();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
